// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mispredict flush/redirect,
// data-memory wait and WFI sleep, plus a saturating stalled-cycle counter.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_index,
  input  logic [4:0]  id_rs2_index,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd_index,
  input  logic        ex_load,
  input  logic        t_pnt,
  input  logic        nt_pt,
  input  logic        dm_wait,
  input  logic        wfi_req,
  input  logic        irq_pending,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_flush,
  output logic        wait_dm,
  output logic        wait_wfi,
  output logic        wfi_wake,
  output logic [2:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    REDIR   = 3'd1,
    MEMWAIT = 3'd2,
    WFI     = 3'd3
  } state_t;

  state_t cur_state;
  state_t next_state;
  logic   pend_flush;
  logic   pend_flush_next;
  logic   lu;
  logic   mp;

  assign lu = ex_load && (ex_rd_index != 5'd0) &&
              ((id_use_rs1 && (id_rs1_index == ex_rd_index)) ||
               (id_use_rs2 && (id_rs2_index == ex_rd_index)));
  assign mp = t_pnt || nt_pt;

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= RUN;
      pend_flush <= 1'b0;
      stall_cnt  <= 16'd0;
    end else begin
      cur_state  <= next_state;
      pend_flush <= pend_flush_next;
      if (pc_hold && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    next_state      = RUN;
    pend_flush_next = pend_flush;
    pc_hold         = 1'b0;
    ifid_hold       = 1'b0;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    idex_flush      = 1'b0;
    wait_dm         = 1'b0;
    wait_wfi        = 1'b0;
    wfi_wake        = 1'b0;

    case (cur_state)
      RUN: begin
        if (mp) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          next_state = REDIR;
        end else if (dm_wait) begin
          wait_dm    = 1'b1;
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          next_state = MEMWAIT;
        end else if (wfi_req) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          next_state = WFI;
        end else if (lu) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
      end

      REDIR: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end

      // A mispredict seen on the exit cycle itself is treated like a pending one.
      MEMWAIT: begin
        if (dm_wait) begin
          wait_dm    = 1'b1;
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          next_state = MEMWAIT;
          if (mp)
            pend_flush_next = 1'b1;
        end else if (pend_flush || mp) begin
          ifid_flush      = 1'b1;
          idex_flush      = 1'b1;
          next_state      = REDIR;
          pend_flush_next = 1'b0;
        end else begin
          pend_flush_next = 1'b0;
        end
      end

      WFI: begin
        wait_wfi  = 1'b1;
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        if (irq_pending)
          wfi_wake = 1'b1;
        else
          next_state = WFI;
      end

      default: begin
        pend_flush_next = 1'b0;
      end
    endcase

    if (ifid_flush)
      ifid_hold = 1'b0;

    if (rst) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      idex_flush  = 1'b0;
      wait_dm     = 1'b0;
      wait_wfi    = 1'b0;
      wfi_wake    = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] F_PC = 8'h80;
  localparam logic [7:0] F_IH = 8'h40;
  localparam logic [7:0] F_IF = 8'h20;
  localparam logic [7:0] F_IB = 8'h10;
  localparam logic [7:0] F_XF = 8'h08;
  localparam logic [7:0] F_WD = 8'h04;
  localparam logic [7:0] F_WW = 8'h02;
  localparam logic [7:0] F_WK = 8'h01;

  localparam logic [2:0] S_RUN = 3'd0;
  localparam logic [2:0] S_REDIR = 3'd1;
  localparam logic [2:0] S_MEMWAIT = 3'd2;
  localparam logic [2:0] S_WFI = 3'd3;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] exd;
    logic       exl;
    logic       tp;
    logic       np;
    logic       dmw;
    logic       wfi;
    logic       irq;
  } in_t;

  typedef struct {
    string       name;
    logic [7:0]  flags;
    logic [2:0]  st;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_index;
  logic [4:0]  id_rs2_index;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd_index;
  logic        ex_load;
  logic        t_pnt;
  logic        nt_pt;
  logic        dm_wait;
  logic        wfi_req;
  logic        irq_pending;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        idex_flush;
  logic        wait_dm;
  logic        wait_wfi;
  logic        wfi_wake;
  logic [2:0]  state;
  logic [15:0] stall_cnt;

  exp_t        sb[$];
  in_t         nxt;
  logic [15:0] exp_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_index (id_rs1_index),
    .id_rs2_index (id_rs2_index),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd_index  (ex_rd_index),
    .ex_load      (ex_load),
    .t_pnt        (t_pnt),
    .nt_pt        (nt_pt),
    .dm_wait      (dm_wait),
    .wfi_req      (wfi_req),
    .irq_pending  (irq_pending),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .idex_flush   (idex_flush),
    .wait_dm      (wait_dm),
    .wait_wfi     (wait_wfi),
    .wfi_wake     (wfi_wake),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs from nxt; the expected stall count follows the expected pc_hold.
  task automatic applyStimulus(input string name, input logic [7:0] ef,
                               input logic [2:0] es, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = nxt.rst;
    id_rs1_index = nxt.rs1;
    id_rs2_index = nxt.rs2;
    id_use_rs1   = nxt.use1;
    id_use_rs2   = nxt.use2;
    ex_rd_index  = nxt.exd;
    ex_load      = nxt.exl;
    t_pnt        = nxt.tp;
    nt_pt        = nxt.np;
    dm_wait      = nxt.dmw;
    wfi_req      = nxt.wfi;
    irq_pending  = nxt.irq;
    if (chk) begin
      e.name  = name;
      e.flags = ef;
      e.st    = es;
      e.cnt   = exp_cnt;
      sb.push_back(e);
    end
    if (nxt.rst)
      exp_cnt = 16'd0;
    else if (((ef & F_PC) != 8'd0) && (exp_cnt != 16'hFFFF))
      exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {pc_hold, ifid_hold, ifid_flush, idex_bubble,
           idex_flush, wait_dm, wait_wfi, wfi_wake};
    vectors++;
    if (act !== e.flags || state !== e.st || stall_cnt !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL %s: got flags=%b state=%0d cnt=%h, want flags=%b state=%0d cnt=%h",
               e.name, act, state, stall_cnt, e.flags, e.st, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0)
      checkOutput(sb.pop_front());
  end

  initial begin
    exp_cnt = 16'd0;
    nxt = '0;
    nxt.rst = 1'b1;
    applyStimulus("init_rst", 8'h00, S_RUN, 1'b0);
    applyStimulus("reset_state", 8'h00, S_RUN, 1'b1);

    // Load-use on rs2, then non-hazard variants.
    nxt = '0; nxt.exl = 1; nxt.exd = 5; nxt.rs2 = 5; nxt.use2 = 1;
    applyStimulus("lu_rs2", F_PC | F_IH | F_IB, S_RUN, 1'b1);
    nxt = '0;
    applyStimulus("lu_after", 8'h00, S_RUN, 1'b1);
    nxt = '0; nxt.exl = 1; nxt.exd = 0; nxt.rs2 = 0; nxt.use2 = 1;
    applyStimulus("lu_rd0", 8'h00, S_RUN, 1'b1);
    nxt = '0; nxt.exl = 1; nxt.exd = 7; nxt.rs1 = 7; nxt.use1 = 0;
    applyStimulus("lu_nouse", 8'h00, S_RUN, 1'b1);
    nxt = '0; nxt.exl = 0; nxt.exd = 7; nxt.rs1 = 7; nxt.use1 = 1;
    applyStimulus("lu_noload", 8'h00, S_RUN, 1'b1);
    nxt = '0; nxt.exl = 1; nxt.exd = 7; nxt.rs1 = 7; nxt.use1 = 1; nxt.rs2 = 3; nxt.use2 = 1;
    applyStimulus("lu_rs1_a", F_PC | F_IH | F_IB, S_RUN, 1'b1);
    applyStimulus("lu_rs1_b", F_PC | F_IH | F_IB, S_RUN, 1'b1);

    // Taken mispredict; mp and dm_wait during REDIR are ignored.
    nxt = '0; nxt.tp = 1;
    applyStimulus("mp_c0", F_IF | F_XF, S_RUN, 1'b1);
    nxt = '0; nxt.tp = 1; nxt.dmw = 1;
    applyStimulus("mp_c1", F_IF | F_IB, S_REDIR, 1'b1);
    nxt = '0;
    applyStimulus("mp_c2", 8'h00, S_RUN, 1'b1);

    // Priority: every event at once, then dm_wait over wfi/lu.
    nxt = '0; nxt.np = 1; nxt.dmw = 1; nxt.wfi = 1;
    nxt.exl = 1; nxt.exd = 4; nxt.rs1 = 4; nxt.use1 = 1;
    applyStimulus("prio_mp", F_IF | F_XF, S_RUN, 1'b1);
    nxt = '0;
    applyStimulus("prio_mp_redir", F_IF | F_IB, S_REDIR, 1'b1);
    nxt = '0; nxt.dmw = 1; nxt.wfi = 1; nxt.exl = 1; nxt.exd = 4; nxt.rs1 = 4; nxt.use1 = 1;
    applyStimulus("prio_dm", F_PC | F_IH | F_WD, S_RUN, 1'b1);
    nxt = '0;
    applyStimulus("dm_exit", 8'h00, S_MEMWAIT, 1'b1);
    applyStimulus("dm_run", 8'h00, S_RUN, 1'b1);

    // dm_wait four cycles with nt_pt in the second: pending flush on exit.
    nxt = '0; nxt.dmw = 1;
    applyStimulus("dmw_c0", F_PC | F_IH | F_WD, S_RUN, 1'b1);
    nxt.np = 1;
    applyStimulus("dmw_c1", F_PC | F_IH | F_WD, S_MEMWAIT, 1'b1);
    nxt.np = 0;
    applyStimulus("dmw_c2", F_PC | F_IH | F_WD, S_MEMWAIT, 1'b1);
    applyStimulus("dmw_c3", F_PC | F_IH | F_WD, S_MEMWAIT, 1'b1);
    nxt = '0;
    applyStimulus("dmw_flush", F_IF | F_XF, S_MEMWAIT, 1'b1);
    applyStimulus("dmw_redir", F_IF | F_IB, S_REDIR, 1'b1);
    applyStimulus("dmw_run", 8'h00, S_RUN, 1'b1);

    // WFI over lu, woken after ten sleeping cycles.
    nxt = '0; nxt.wfi = 1; nxt.exl = 1; nxt.exd = 9; nxt.rs2 = 9; nxt.use2 = 1;
    applyStimulus("wfi_enter", F_PC | F_IH, S_RUN, 1'b1);
    nxt = '0;
    for (int i = 1; i <= 10; i++)
      applyStimulus($sformatf("wfi_sleep%0d", i), F_PC | F_IH | F_WW, S_WFI, 1'b1);
    nxt.irq = 1;
    applyStimulus("wfi_wake", F_PC | F_IH | F_WW | F_WK, S_WFI, 1'b1);
    nxt = '0;
    applyStimulus("wfi_run", 8'h00, S_RUN, 1'b1);

    // irq already pending on entry: a single WFI cycle.
    nxt = '0; nxt.wfi = 1; nxt.irq = 1;
    applyStimulus("wfi_irq_enter", F_PC | F_IH, S_RUN, 1'b1);
    nxt.wfi = 0;
    applyStimulus("wfi_irq_one", F_PC | F_IH | F_WW | F_WK, S_WFI, 1'b1);
    nxt = '0;
    applyStimulus("wfi_irq_run", 8'h00, S_RUN, 1'b1);

    // Reset in MEMWAIT with a pending flush: nothing survives.
    nxt = '0; nxt.dmw = 1;
    applyStimulus("rst_mw_c0", F_PC | F_IH | F_WD, S_RUN, 1'b1);
    nxt.np = 1;
    applyStimulus("rst_mw_c1", F_PC | F_IH | F_WD, S_MEMWAIT, 1'b1);
    nxt.np = 0; nxt.rst = 1;
    applyStimulus("rst_mw_rst", 8'h00, S_MEMWAIT, 1'b1);
    nxt = '0;
    applyStimulus("rst_mw_after", 8'h00, S_RUN, 1'b1);
    applyStimulus("rst_mw_after2", 8'h00, S_RUN, 1'b1);

    // Reset in REDIR.
    nxt = '0; nxt.tp = 1;
    applyStimulus("rst_rd_mp", F_IF | F_XF, S_RUN, 1'b1);
    nxt = '0; nxt.rst = 1;
    applyStimulus("rst_rd_rst", 8'h00, S_REDIR, 1'b1);
    nxt = '0;
    applyStimulus("rst_rd_after", 8'h00, S_RUN, 1'b1);

    // Reset in WFI without irq.
    nxt = '0; nxt.wfi = 1;
    applyStimulus("rst_wfi_enter", F_PC | F_IH, S_RUN, 1'b1);
    nxt = '0;
    applyStimulus("rst_wfi_sleep", F_PC | F_IH | F_WW, S_WFI, 1'b1);
    nxt.rst = 1;
    applyStimulus("rst_wfi_rst", 8'h00, S_WFI, 1'b1);
    nxt = '0;
    applyStimulus("rst_wfi_after", 8'h00, S_RUN, 1'b1);

    // Long WFI sleep drives stall_cnt to saturation.
    nxt = '0; nxt.wfi = 1;
    applyStimulus("sat_enter", F_PC | F_IH, S_RUN, 1'b1);
    nxt = '0;
    for (int i = 0; i < 65540; i++)
      applyStimulus("sat_sleep", F_PC | F_IH | F_WW, S_WFI, 1'b0);
    applyStimulus("sat_hold", F_PC | F_IH | F_WW, S_WFI, 1'b1);
    nxt.irq = 1;
    applyStimulus("sat_wake", F_PC | F_IH | F_WW | F_WK, S_WFI, 1'b1);
    nxt = '0;
    applyStimulus("sat_run", 8'h00, S_RUN, 1'b1);
    applyStimulus("sat_run2", 8'h00, S_RUN, 1'b1);

    for (int i = 0; i < 4 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
